mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - matrix-vector MAC sequencer: fetches rows, unpacks bytes into FIFOs, runs MAC.
// Rows 0..NUM_ROWS-1 feed the A FIFOs; row NUM_ROWS is the B vector.
module mac_sequencer #(
  parameter int          DATA_W    = 8,
  parameter int          NUM_ROWS  = 8,
  parameter int          VEC_LEN   = 8,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAC_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [31:0]                 mem_addr,
  output logic                        mem_read,
  input  logic                        mem_waitrequest,
  input  logic [DATA_W*VEC_LEN-1:0]   mem_readdata,
  input  logic                        mem_readdatavalid,
  output logic [NUM_ROWS:0]           fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  input  logic [NUM_ROWS:0]           fifo_full,
  output logic                        mac_clr,
  output logic                        mac_en,
  output logic                        busy,
  output logic                        done
);

  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam int BW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int CW = $clog2(VEC_LEN + MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [RW-1:0]     row_idx, row_idx_nx;
  logic [BW-1:0]     bcnt, bcnt_nx;
  logic [CW-1:0]     ccnt, ccnt_nx;
  logic              clr_q, clr_nx;
  logic              capture;
  logic [DATA_W-1:0] row_buf [VEC_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row_idx <= '0;
      bcnt    <= '0;
      ccnt    <= '0;
      clr_q   <= 1'b0;
      for (int k = 0; k < VEC_LEN; k++) row_buf[k] <= '0;
    end else begin
      state   <= state_nx;
      row_idx <= row_idx_nx;
      bcnt    <= bcnt_nx;
      ccnt    <= ccnt_nx;
      clr_q   <= clr_nx;
      if (capture) begin
        for (int k = 0; k < VEC_LEN; k++) row_buf[k] <= mem_readdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    row_idx_nx = row_idx;
    bcnt_nx    = bcnt;
    ccnt_nx    = ccnt;
    clr_nx     = 1'b0;
    capture    = 1'b0;
    mem_read   = 1'b0;
    fifo_wr_en = '0;
    mac_en     = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx   = S_REQ;
          row_idx_nx = '0;
          clr_nx     = 1'b1;
        end
      end
      S_REQ: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          capture  = 1'b1;
          bcnt_nx  = '0;
          state_nx = S_UNPACK;
        end
      end
      S_UNPACK: begin
        // A full target FIFO simply freezes the byte counter for that cycle
        if (!fifo_full[row_idx]) begin
          fifo_wr_en[row_idx] = 1'b1;
          if (bcnt == BW'(VEC_LEN - 1)) begin
            bcnt_nx = '0;
            if (row_idx == RW'(NUM_ROWS)) begin
              ccnt_nx  = '0;
              state_nx = S_COMPUTE;
            end else begin
              row_idx_nx = row_idx + 1'b1;
              state_nx   = S_REQ;
            end
          end else begin
            bcnt_nx = bcnt + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        mac_en = 1'b1;
        if (ccnt == CW'(VEC_LEN - 1)) begin
          ccnt_nx  = '0;
          state_nx = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          ccnt_nx = ccnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (ccnt == CW'(MAC_LAT - 1)) begin
          ccnt_nx  = '0;
          state_nx = S_DONE;
        end else begin
          ccnt_nx = ccnt + 1'b1;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign mac_clr      = clr_q;
  assign fifo_wr_data = row_buf[bcnt];
  assign mem_addr     = BASE_ADDR + 32'(row_idx);

endmodule
